// File: rtl/idli_pkg.sv
// Shared idli core types: the SQI nibble plus the UART controller's state,
// parity and RX FIFO entry types and its parity helper.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [1:0] {
    UART_PAR_NONE = 2'd0,
    UART_PAR_EVEN = 2'd1,
    UART_PAR_ODD  = 2'd2
  } uart_parity_t;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_HI    = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_PAR   = 3'd4,
    TX_STOP  = 3'd5
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4
  } uart_rx_state_t;

  typedef enum logic {
    OUT_LO = 1'b0,
    OUT_HI = 1'b1
  } uart_out_state_t;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } uart_rx_entry_t;

  function automatic logic uart_parity(input logic [7:0] data, input uart_parity_t mode);
    return (^data) ^ (mode == UART_PAR_ODD);
  endfunction

endpackage

// File: rtl/idli_uart_fifo_m.sv
// RX byte FIFO. A push while full only lands when a pop happens in the same
// cycle; otherwise the caller treats it as dropped.
module idli_uart_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  uart_rx_entry_t data_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output uart_rx_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  uart_rx_entry_t mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic           wr_en_s;
  logic           rd_en_s;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign rd_en_s = pop_i && !empty_o;
  assign wr_en_s = push_i && (!full_o || rd_en_s);
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en_s) begin
        wr_q <= wr_q + AW'(1);
      end
      if (rd_en_s) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/idli_uart_ctl_m.sv
// UART controller between the core's 4b low-then-high nibble bus and the
// serial pins: programmable bit period, optional parity, buffered RX.
module idli_uart_ctl_m
  import idli_pkg::*;
#(
  parameter int CLK_PER_BIT = 1,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int RX_DEPTH    = 4
) (
  input  logic      i_uart_gck,
  input  logic      i_uart_rst,
  input  logic      i_uart_rx,
  output logic      o_uart_rx_vld,
  input  logic      i_uart_rx_acp,
  output sqi_data_t o_uart_rx,
  output logic      o_uart_rx_err,
  output logic      o_uart_rx_ovf,
  input  logic      i_uart_ovf_clr,
  input  sqi_data_t i_uart_tx,
  input  logic      i_uart_tx_vld,
  output logic      o_uart_tx_acp,
  output logic      o_uart_tx
);

  localparam uart_parity_t PAR_MODE = (PARITY == 2) ? UART_PAR_ODD :
                                      ((PARITY == 1) ? UART_PAR_EVEN : UART_PAR_NONE);
  localparam bit PAR_EN = (PAR_MODE != UART_PAR_NONE);
  localparam int CNT_W  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_PER_BIT - 1);
  // Lands the start-bit resample in the middle of the start bit.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((CLK_PER_BIT > 1) ? (CLK_PER_BIT / 2) - 1 : 0);
  localparam logic [2:0]       STOP_LOAD = 3'(STOP_BITS - 1);

  uart_tx_state_t   tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_idx_q;
  logic [7:0]       tx_data_q;
  logic             tx_q;
  logic             tx_acp_q;

  uart_rx_state_t   rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_idx_q;
  logic [7:0]       rx_data_q;
  logic             rx_par_err_q;
  logic             rx_push_s;
  uart_rx_entry_t   rx_entry_s;

  uart_out_state_t  out_q;
  logic             ovf_q;
  logic             pop_s;
  logic             drop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  uart_rx_entry_t   fifo_head_s;

  // TX framing; tx_idx_q counts data bits, then remaining stop bits.
  always_ff @(posedge i_uart_gck) begin
    if (i_uart_rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_q       <= 1'b1;
      tx_acp_q   <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (i_uart_tx_vld) begin
            tx_data_q[3:0] <= i_uart_tx;
            tx_state_q     <= TX_HI;
          end
        end
        TX_HI: begin
          tx_data_q[7:4] <= i_uart_tx;
          tx_state_q     <= TX_START;
          tx_q           <= 1'b0;
          tx_acp_q       <= 1'b0;
          tx_cnt_q       <= BIT_LOAD;
        end
        TX_START: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= TX_DATA;
            tx_q       <= tx_data_q[0];
            tx_idx_q   <= 3'd0;
            tx_cnt_q   <= BIT_LOAD;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= BIT_LOAD;
            if (tx_idx_q != 3'd7) begin
              tx_idx_q <= tx_idx_q + 3'd1;
              tx_q     <= tx_data_q[tx_idx_q + 3'd1];
            end else if (PAR_EN) begin
              tx_state_q <= TX_PAR;
              tx_q       <= uart_parity(tx_data_q, PAR_MODE);
            end else begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
              tx_idx_q   <= STOP_LOAD;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_PAR: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= TX_STOP;
            tx_q       <= 1'b1;
            tx_idx_q   <= STOP_LOAD;
            tx_cnt_q   <= BIT_LOAD;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
          end else if (tx_idx_q == 3'd0) begin
            tx_state_q <= TX_IDLE;
            tx_acp_q   <= 1'b1;
          end else begin
            tx_idx_q <= tx_idx_q - 3'd1;
            tx_cnt_q <= BIT_LOAD;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
          tx_acp_q   <= 1'b1;
        end
      endcase
    end
  end

  // RX framing with mid-bit sampling; a high line at the start resample is a glitch.
  always_ff @(posedge i_uart_gck) begin
    if (i_uart_rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= 3'd0;
      rx_data_q    <= 8'h00;
      rx_par_err_q <= 1'b0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!i_uart_rx) begin
            rx_idx_q     <= 3'd0;
            rx_par_err_q <= 1'b0;
            if (CLK_PER_BIT == 1) begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= '0;
            end else begin
              rx_state_q <= RX_START;
              rx_cnt_q   <= HALF_LOAD;
            end
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q   <= BIT_LOAD;
            rx_state_q <= i_uart_rx ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_data_q[rx_idx_q] <= i_uart_rx;
            rx_cnt_q            <= BIT_LOAD;
            if (rx_idx_q == 3'd7) begin
              rx_state_q <= PAR_EN ? RX_PAR : RX_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_PAR: begin
          if (rx_cnt_q == '0) begin
            rx_par_err_q <= i_uart_rx ^ uart_parity(rx_data_q, PAR_MODE);
            rx_cnt_q     <= BIT_LOAD;
            rx_state_q   <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_ONE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_push_s       = (rx_state_q == RX_STOP) && (rx_cnt_q == '0);
    rx_entry_s.err  = rx_par_err_q | ~i_uart_rx;
    rx_entry_s.data = rx_data_q;
  end

  assign pop_s  = (out_q == OUT_HI);
  assign drop_s = rx_push_s && fifo_full_s && !pop_s;

  idli_uart_fifo_m #(
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk_i   (i_uart_gck),
    .rst_i   (i_uart_rst),
    .push_i  (rx_push_s),
    .data_i  (rx_entry_s),
    .pop_i   (pop_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (fifo_head_s)
  );

  // Core-side nibble sequencing; the head pops at the end of OUT_HI.
  always_ff @(posedge i_uart_gck) begin
    if (i_uart_rst) begin
      out_q <= OUT_LO;
    end else begin
      case (out_q)
        OUT_LO:  out_q <= (i_uart_rx_acp && !fifo_empty_s) ? OUT_HI : OUT_LO;
        OUT_HI:  out_q <= OUT_LO;
        default: out_q <= OUT_LO;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_uart_gck) begin
    if (i_uart_rst) begin
      ovf_q <= 1'b0;
    end else if (drop_s) begin
      ovf_q <= 1'b1;
    end else if (i_uart_ovf_clr) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign o_uart_tx     = tx_q;
  assign o_uart_tx_acp = tx_acp_q;
  assign o_uart_rx_vld = (out_q == OUT_LO) && !fifo_empty_s;
  assign o_uart_rx     = fifo_empty_s ? 4'h0 :
                         ((out_q == OUT_HI) ? fifo_head_s.data[7:4] : fifo_head_s.data[3:0]);
  assign o_uart_rx_err = o_uart_rx_vld && fifo_head_s.err;
  assign o_uart_rx_ovf = ovf_q;

endmodule

// File: doc/idli_uart_ctl_m.md
# idli_uart_ctl_m

Parametrised UART controller that replaces the fixed 1-clock-per-bit UART between the core's 4b nibble bus and the serial pins. It adds a programmable bit period, optional parity, 1 or 2 stop bits, mid-bit RX sampling with false-start rejection, and an RX byte FIFO with error and overflow reporting. The core-side handshake keeps the existing 4b low-then-high nibble format, so the core needs no changes.

## Interface
- CLK_PER_BIT, default 1: clock cycles per serial bit, at least 1.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: 1 or 2.
- RX_DEPTH, default 4: RX FIFO depth in bytes, a power of 2 and at least 2.
- i_uart_gck  in  1  clock.
- i_uart_rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_uart_rx  in  1  serial RX line; idles high.
- o_uart_rx_vld  out  1  low nibble of the FIFO head is valid.
- i_uart_rx_acp  in  1  core accepts the low nibble.
- o_uart_rx  out  sqi_data_t (4)  RX nibble.
- o_uart_rx_err  out  1  the head byte has a parity or framing error; qualified by o_uart_rx_vld.
- o_uart_rx_ovf  out  1  sticky: a byte was dropped because the FIFO was full.
- i_uart_ovf_clr  in  1  clears o_uart_rx_ovf.
- i_uart_tx  in  sqi_data_t (4)  TX nibble.
- i_uart_tx_vld  in  1  low nibble of a TX byte is valid.
- o_uart_tx_acp  out  1  block accepts a TX nibble.
- o_uart_tx  out  1  serial TX line.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, then STOP_BITS stop bits (1). Each bit lasts CLK_PER_BIT cycles, timed by a shared-style down-counter per direction.
- TX FSM:
  - TX_IDLE: o_uart_tx_acp=1. On i_uart_tx_vld, capture the nibble as bits [3:0] and go to TX_HI.
  - TX_HI: o_uart_tx_acp=1 and capture the nibble as bits [7:4] unconditionally. The core always drives the high nibble in this cycle. Go to TX_START.
  - TX_START, then TX_DATA (bit index 0..7), then TX_PAR (only if PARITY≠0), then TX_STOP (STOP_BITS periods), then TX_IDLE.
  - o_uart_tx is 1 in TX_IDLE and TX_HI. Parity is the XOR of the data bits; odd parity inverts it.
- RX FSM:
  - RX_IDLE: on i_uart_rx=0, load the counter with CLK_PER_BIT/2 (integer division) and go to RX_START.
  - RX_START: when the counter expires, resample. If the line is 1 this is a false start; return to RX_IDLE. If 0, go to RX_DATA.
  - RX_DATA: sample each subsequent bit every CLK_PER_BIT cycles. Then RX_PAR (if enabled), then RX_STOP, which samples the first stop bit only.
  - At the RX_STOP sample, push {err, byte} and return to RX_IDLE. err = parity mismatch OR stop sample = 0.
  - With CLK_PER_BIT=1 the first data bit is sampled in the cycle after the start bit is seen.
- FIFO push when full: the byte is dropped and o_uart_rx_ovf is set. If a pop happens in the same cycle, the push succeeds and nothing is dropped.
- RX output side:
  - OUT_LO: o_uart_rx_vld = FIFO not empty; o_uart_rx = head[3:0]. On i_uart_rx_acp, go to OUT_HI.
  - OUT_HI: o_uart_rx_vld=0 (required for clock gating); o_uart_rx = head[7:4]. Pop at the end of the cycle and return to OUT_LO.
  - o_uart_rx is 0 when the FIFO is empty.
- ovf set and clear in the same cycle: set wins.

## Timing
- Reset values: o_uart_tx=1, o_uart_tx_acp=1, o_uart_rx_vld=0, o_uart_rx=0, o_uart_rx_err=0, o_uart_rx_ovf=0. Both FSMs go idle and the FIFO empties.
- Reset asserted mid-frame: o_uart_tx returns to 1 on the next cycle and any partially received byte is discarded.
- TX: low nibble accepted at cycle T, high nibble at T+1, start bit driven from T+2. A frame lasts (10 + P + STOP_BITS − 1)·CLK_PER_BIT cycles. o_uart_tx_acp rises in the cycle after the last stop-bit cycle.
- RX: the pushed byte raises o_uart_rx_vld in the cycle after the stop sample. With RX_DEPTH ≥ 2, back-to-back bytes can be read every 2 cycles.

## Structure
- Add to idli_pkg: uart_parity_t enum (UART_PAR_NONE, UART_PAR_EVEN, UART_PAR_ODD), uart_tx_state_t, uart_rx_state_t, and uart_rx_entry_t {err, data[7:0]}.
- Sub-module idli_uart_fifo_m: parameter DEPTH; ports for push, pop, full, empty and head; synchronous active-high reset.
- TX, RX and output-side FSMs live in idli_uart_ctl_m.

## Test plan
- Defaults (CLK_PER_BIT=1, no parity, 1 stop), TX 0xA5 as nibbles 5 then A -> o_uart_tx from T+2 is 0,1,0,1,0,0,1,0,1,1; o_uart_tx_acp low for 10 cycles.
- CLK_PER_BIT=4, PARITY=even, RX frame 0x3C with parity 0 -> o_uart_rx_vld with nibble C and err=0; after acp, next cycle shows nibble 3 with vld=0.
- RX frame with stop bit 0, and separately a frame with a flipped parity bit -> byte delivered with o_uart_rx_err=1.
- RX_DEPTH=2, three bytes 0x11, 0x22, 0x33 received with no acp -> 0x11 then 0x22 read in order, 0x33 lost, o_uart_rx_ovf=1 until i_uart_ovf_clr.
- CLK_PER_BIT=8, a 2-cycle low glitch on i_uart_rx -> no FIFO push, RX FSM back in RX_IDLE.
- i_uart_rst asserted during TX data bit 3 and mid-RX -> next cycle o_uart_tx=1, o_uart_tx_acp=1, o_uart_rx_vld=0; a following clean frame is received correctly.
